// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forward control for a 5-stage pipeline with a
// multi-cycle divide that occupies EX for DIV_CYCLES cycles.
module hazard_fwd_unit #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_waddr,
    input  logic       id_we,
    input  logic       id_is_load,
    input  logic       id_is_div,
    output logic       control_rdata_a,
    output logic       control_rdata_b,
    output logic       fwd_ex_a,
    output logic       fwd_ex_b,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       bubble_ex,
    output logic       div_busy
);

    localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] waddr;
        logic       is_load;
    } slot_t;

    // WB producers need no tracking here: the register file is write-through.
    slot_t      ex_q, ex_d;
    slot_t      mem_q, mem_d;
    logic [5:0] div_cnt_q, div_cnt_d;
    logic       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       ctl_a_q, ctl_a_d, ctl_b_q, ctl_b_d;

    logic ex_wr, mem_wr;
    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, busy;

    always_comb begin
        ex_wr    = ex_q.valid & ex_q.we & (ex_q.waddr != 5'd0);
        mem_wr   = mem_q.valid & mem_q.we & (mem_q.waddr != 5'd0);
        rs_ex    = id_valid & id_use_rs & ex_wr & (ex_q.waddr == id_rs);
        rt_ex    = id_valid & id_use_rt & ex_wr & (ex_q.waddr == id_rt);
        rs_mem   = id_valid & id_use_rs & mem_wr & (mem_q.waddr == id_rs);
        rt_mem   = id_valid & id_use_rt & mem_wr & (mem_q.waddr == id_rt);
        load_use = ex_q.is_load & (rs_ex | rt_ex);
        busy     = (div_cnt_q != 6'd0);
    end

    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        div_cnt_d = div_cnt_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
        ctl_a_d   = ctl_a_q;
        ctl_b_d   = ctl_b_q;
        if (busy) begin
            // EX and selects frozen behind the divide; MEM fills with bubbles.
            div_cnt_d   = div_cnt_q - 6'd1;
            mem_d.valid = 1'b0;
        end else if (load_use) begin
            mem_d    = ex_q;
            ex_d     = '0;
            fwd_a_d  = 1'b0;
            fwd_b_d  = 1'b0;
            ctl_a_d  = 1'b0;
            ctl_b_d  = 1'b0;
        end else begin
            mem_d      = ex_q;
            ex_d.valid   = id_valid;
            ex_d.we      = id_we;
            ex_d.waddr   = id_waddr;
            ex_d.is_load = id_is_load;
            // EX producer is youngest, so it wins over MEM.
            fwd_a_d = rs_ex;
            fwd_b_d = rt_ex;
            ctl_a_d = rs_mem & ~rs_ex;
            ctl_b_d = rt_mem & ~rt_ex;
            if (id_valid && id_is_div) begin
                div_cnt_d = DivLoad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            div_cnt_q <= 6'd0;
            fwd_a_q   <= 1'b0;
            fwd_b_q   <= 1'b0;
            ctl_a_q   <= 1'b0;
            ctl_b_q   <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            div_cnt_q <= div_cnt_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            ctl_a_q   <= ctl_a_d;
            ctl_b_q   <= ctl_b_d;
        end
    end

    always_comb begin
        control_rdata_a = ctl_a_q;
        control_rdata_b = ctl_b_q;
        fwd_ex_a        = fwd_a_q;
        fwd_ex_b        = fwd_b_q;
        div_busy        = busy;
        stall_ex        = busy;
        stall_if        = busy | load_use;
        stall_id        = busy | load_use;
        bubble_ex       = load_use & ~busy;
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomized scoreboard bench for hazard_fwd_unit against a producer-list
// reference model.
module tb_hazard_fwd_unit;

    localparam int DIV_CYCLES = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_we, id_is_load, id_is_div;
    logic [4:0] id_rs, id_rt, id_waddr;
    logic       control_rdata_a, control_rdata_b, fwd_ex_a, fwd_ex_b;
    logic       stall_if, stall_id, stall_ex, bubble_ex, div_busy;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_waddr(id_waddr), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_div(id_is_div),
        .control_rdata_a(control_rdata_a), .control_rdata_b(control_rdata_b),
        .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex), .div_busy(div_busy)
    );

    // Reference model: a producer is just (valid, destination-or-0, is_load).
    typedef struct {
        bit valid;
        int dest;
        bit load;
    } prod_t;

    prod_t m_ex, m_mem;
    int    div_left;
    bit    m_fa, m_fb, m_ca, m_cb;

    logic [8:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cycle = 0;

    function automatic bit produces(prod_t p, int r);
        return p.valid && p.dest != 0 && p.dest == r;
    endfunction

    function automatic bit hits(prod_t p);
        return id_valid && ((id_use_rs && produces(p, int'(id_rs))) ||
                            (id_use_rt && produces(p, int'(id_rt))));
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int wa, input bit we, input bit ld, input bit dv, input bit rn);
        bit busy, lu;
        @(negedge clk);
        rst_n = rn; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_waddr = 5'(wa); id_we = we;
        id_is_load = ld; id_is_div = dv;
        #1;
        busy = div_left > 0;
        lu   = m_ex.load && hits(m_ex);
        exp_q.push_back({m_ca, m_cb, m_fa, m_fb, busy | lu, busy | lu, busy, lu & !busy, busy});
        @(posedge clk);
        if (!rn) begin
            m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; div_left = 0;
            m_fa = 0; m_fb = 0; m_ca = 0; m_cb = 0;
        end else if (busy) begin
            div_left--;
            m_mem.valid = 0;
        end else if (lu) begin
            m_mem = m_ex;
            m_ex  = '{0, 0, 0};
            m_fa = 0; m_fb = 0; m_ca = 0; m_cb = 0;
        end else begin
            m_fa = v && urs && produces(m_ex, rs);
            m_fb = v && urt && produces(m_ex, rt);
            m_ca = v && urs && !m_fa && produces(m_mem, rs);
            m_cb = v && urt && !m_fb && produces(m_mem, rt);
            m_mem = m_ex;
            m_ex  = '{v, we ? wa : 0, ld};
            if (v && dv) div_left = DIV_CYCLES - 1;
        end
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: one expected output vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e, got;
        #2;
        cycle++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {control_rdata_a, control_rdata_b, fwd_ex_a, fwd_ex_b,
                   stall_if, stall_id, stall_ex, bubble_ex, div_busy};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL outputs cycle %0d: got %b expected %b (ca cb fa fb sif sid sex bub busy)",
                         cycle, got, e);
            end
        end
    end

    initial begin
        m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; div_left = 0;
        m_fa = 0; m_fb = 0; m_ca = 0; m_cb = 0;
        rst_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_waddr = 0; id_we = 0; id_is_load = 0; id_is_div = 0;
        repeat (2) @(posedge clk);

        // add r3 ; add r4,r3,r1
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
        step(1, 3, 1, 1, 1, 4, 1, 0, 0, 1);
        nop();
        // lw r5 ; sub r6,r5,r5 (held in ID across the stall)
        step(1, 0, 0, 0, 0, 5, 1, 1, 0, 1);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
        nop(); nop();
        // write r0 then read r0
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step(1, 0, 0, 1, 1, 9, 1, 0, 0, 1);
        nop();
        // divide: 31 busy cycles
        step(1, 1, 2, 1, 1, 8, 1, 0, 1, 1);
        repeat (DIV_CYCLES + 4) nop();
        // load-use hit by reset
        step(1, 0, 0, 0, 0, 2, 1, 1, 0, 1);
        step(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
        step(1, 2, 0, 1, 0, 3, 1, 0, 0, 1);
        nop();
        // two producers of r7
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 1);
        step(1, 7, 0, 1, 0, 10, 1, 0, 0, 1);
        nop();
        // back-to-back divides
        step(1, 0, 0, 0, 0, 4, 1, 0, 1, 1);
        repeat (DIV_CYCLES - 1) step(1, 4, 0, 1, 0, 5, 1, 0, 1, 1);
        repeat (DIV_CYCLES + 2) nop();

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
